// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, RUN/HALTED
// control and a run-cycle counter. Instruction memory is read combinationally
// at the current PC, so the word presented on i_imem_data belongs to o_imem_addr.
module if_stage #(
  parameter int unsigned        NB_PC       = 11,
  parameter int unsigned        NB_INSTR    = 32,
  parameter int unsigned        NB_OPCODE   = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'h3F,
  parameter logic [NB_PC-1:0]   RESET_PC    = '0,
  parameter int unsigned        NB_CNT      = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_hazard,
  input  logic                i_branch_taken,
  input  logic [NB_PC-1:0]    i_branch_addr,
  output logic [NB_PC-1:0]    o_imem_addr,
  input  logic [NB_INSTR-1:0] i_imem_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic                o_halt,
  output logic [NB_CNT-1:0]   o_cycles
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // An all-zero word decodes as a NOP downstream.
  localparam logic [NB_INSTR-1:0] NOP_INSTR = '0;

  // Sequential PC increment; wraps naturally modulo 2^NB_PC.
  function automatic logic [NB_PC-1:0] pc_inc(input logic [NB_PC-1:0] pc);
    return pc + NB_PC'(1);
  endfunction

  // Free-running counter increment; wraps modulo 2^NB_CNT.
  function automatic logic [NB_CNT-1:0] cnt_inc(input logic [NB_CNT-1:0] cnt);
    return cnt + NB_CNT'(1);
  endfunction

  // True when the fetched word carries the halt opcode in its top field.
  function automatic logic is_halt(input logic [NB_INSTR-1:0] instr);
    return instr[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE;
  endfunction

  state_t               state_q, state_d;
  logic [NB_PC-1:0]     pc_p0, pc_d;
  logic [NB_INSTR-1:0]  instr_p1, instr_d;
  logic [NB_PC-1:0]     pc_next_p1, pc_next_d;
  logic [NB_CNT-1:0]    cycles_q, cycles_d;
  logic [NB_PC-1:0]     pc_plus1;
  logic                 fetch_halt;

  assign pc_plus1   = pc_inc(pc_p0);
  assign fetch_halt = is_halt(i_imem_data);

  // Next-state and next-register selection; everything holds unless stepped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_p0;
    instr_d   = instr_p1;
    pc_next_d = pc_next_p1;
    cycles_d  = cycles_q;
    if (i_valid) begin
      unique case (state_q)
        ST_RUN: begin
          // Stalled cycles still count as time spent running.
          cycles_d = cnt_inc(cycles_q);
          if (i_hazard) begin
            // Full hold; a pending branch is re-evaluated by ID after the stall.
          end else if (i_branch_taken) begin
            // Redirect and squash the word fetched down the wrong path.
            pc_d    = i_branch_addr;
            instr_d = NOP_INSTR;
          end else if (fetch_halt) begin
            // Pass HALT to decode once, then park the PC on it.
            instr_d   = i_imem_data;
            pc_next_d = pc_plus1;
            state_d   = ST_HALTED;
          end else begin
            instr_d   = i_imem_data;
            pc_next_d = pc_plus1;
            pc_d      = pc_plus1;
          end
        end
        ST_HALTED: begin
          // PC frozen and branches ignored; drain HALT into a NOP unless stalled.
          if (!i_hazard) begin
            instr_d = NOP_INSTR;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // IF stage (PC) and IF/ID boundary registers; reset wins over every input.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      pc_p0      <= RESET_PC;
      instr_p1   <= NOP_INSTR;
      pc_next_p1 <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_p0      <= pc_d;
      instr_p1   <= instr_d;
      pc_next_p1 <= pc_next_d;
      cycles_q   <= cycles_d;
    end
  end

  assign o_imem_addr = pc_p0;
  assign o_instr     = instr_p1;
  assign o_pc_next   = pc_next_p1;
  assign o_halt      = (state_q == ST_HALTED);
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a behavioural combinational imem.
module tb_if_stage;

  localparam int NB_PC    = 11;
  localparam int NB_INSTR = 32;
  localparam int NB_CNT   = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic                i_clock = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_valid = 1'b0;
  logic                i_hazard = 1'b0;
  logic                i_branch_taken = 1'b0;
  logic [NB_PC-1:0]    i_branch_addr = '0;
  logic [NB_PC-1:0]    o_imem_addr;
  logic [NB_INSTR-1:0] i_imem_data;
  logic [NB_INSTR-1:0] o_instr;
  logic [NB_PC-1:0]    o_pc_next;
  logic                o_halt;
  logic [NB_CNT-1:0]   o_cycles;

  logic [31:0] imem [0:2047];
  int errors = 0;
  int checks = 0;

  assign i_imem_data = imem[o_imem_addr];

  always #5 i_clock = ~i_clock;

  if_stage dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .i_hazard       (i_hazard),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .o_imem_addr    (o_imem_addr),
    .i_imem_data    (i_imem_data),
    .o_instr        (o_instr),
    .o_pc_next      (o_pc_next),
    .o_halt         (o_halt),
    .o_cycles       (o_cycles)
  );

  // Word for address a: opcode 1, low bits tag the address.
  function automatic logic [31:0] word(input int a);
    return 32'h0400_0000 | 32'(a);
  endfunction

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b1; i_hazard = 1'b0; i_branch_taken = 1'b0;
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    // Dirty the state, then reset with i_valid low: reset must still win.
    do_reset();
    i_valid = 1'b1;
    step(); step();
    i_valid = 1'b0; i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checks++; if (o_imem_addr !== 11'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", o_imem_addr, 11'd0); end
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp %h", o_instr, 32'd0); end
    checks++; if (o_pc_next !== 11'd0) begin errors++; $display("FAIL reset_pcn got %h exp %h", o_pc_next, 11'd0); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", o_halt); end
    checks++; if (o_cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d exp 0", o_cycles); end
  endtask

  task automatic test_sequential();
    do_reset();
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (o_instr !== word(k)) begin errors++; $display("FAIL seq_instr%0d got %h exp %h", k, o_instr, word(k)); end
      checks++; if (o_pc_next !== 11'(k + 1)) begin errors++; $display("FAIL seq_pcn%0d got %h exp %h", k, o_pc_next, k + 1); end
    end
    checks++; if (o_imem_addr !== 11'd4) begin errors++; $display("FAIL seq_pc got %h exp 4", o_imem_addr); end
    checks++; if (o_cycles !== 32'd4) begin errors++; $display("FAIL seq_cycles got %0d exp 4", o_cycles); end
  endtask

  task automatic test_hazard();
    do_reset();
    i_valid = 1'b1;
    step(); step();
    i_hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (o_imem_addr !== 11'd2) begin errors++; $display("FAIL haz_pc%0d got %h exp 2", k, o_imem_addr); end
      checks++; if (o_instr !== word(1)) begin errors++; $display("FAIL haz_instr%0d got %h exp %h", k, o_instr, word(1)); end
    end
    i_hazard = 1'b0;
    step();
    checks++; if (o_instr !== word(2)) begin errors++; $display("FAIL haz_resume got %h exp %h", o_instr, word(2)); end
    checks++; if (o_cycles !== 32'd5) begin errors++; $display("FAIL haz_cycles got %0d exp 5", o_cycles); end
  endtask

  task automatic test_branch();
    // Continues from PC=3 left by test_hazard.
    step(); step();
    checks++; if (o_imem_addr !== 11'd5) begin errors++; $display("FAIL br_pre_pc got %h exp 5", o_imem_addr); end
    i_branch_taken = 1'b1; i_branch_addr = 11'h040;
    step();
    i_branch_taken = 1'b0;
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL br_flush got %h exp 0", o_instr); end
    checks++; if (o_imem_addr !== 11'h040) begin errors++; $display("FAIL br_pc got %h exp 040", o_imem_addr); end
    checks++; if (o_pc_next !== 11'd5) begin errors++; $display("FAIL br_pcn_hold got %h exp 5", o_pc_next); end
    step();
    checks++; if (o_instr !== word(32'h40)) begin errors++; $display("FAIL br_target got %h exp %h", o_instr, word(32'h40)); end
    checks++; if (o_pc_next !== 11'h041) begin errors++; $display("FAIL br_target_pcn got %h exp 041", o_pc_next); end
  endtask

  task automatic test_hazard_over_branch();
    // PC=0x41, IF/ID holds imem[0x40].
    i_hazard = 1'b1; i_branch_taken = 1'b1; i_branch_addr = 11'h080;
    step();
    checks++; if (o_imem_addr !== 11'h041) begin errors++; $display("FAIL hb_pc got %h exp 041", o_imem_addr); end
    checks++; if (o_instr !== word(32'h40)) begin errors++; $display("FAIL hb_instr got %h exp %h", o_instr, word(32'h40)); end
    i_hazard = 1'b0;
    step();
    i_branch_taken = 1'b0;
    checks++; if (o_imem_addr !== 11'h080) begin errors++; $display("FAIL hb_redirect got %h exp 080", o_imem_addr); end
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL hb_flush got %h exp 0", o_instr); end
  endtask

  task automatic test_valid_gate();
    logic [NB_PC-1:0] pc0;
    logic [31:0] in0, cy0;
    step();
    pc0 = o_imem_addr; in0 = o_instr; cy0 = o_cycles;
    i_valid = 1'b0; i_branch_taken = 1'b1; i_branch_addr = 11'h123;
    step(); step(); step();
    i_branch_taken = 1'b0; i_valid = 1'b1;
    checks++; if (o_imem_addr !== pc0) begin errors++; $display("FAIL vg_pc got %h exp %h", o_imem_addr, pc0); end
    checks++; if (o_instr !== in0) begin errors++; $display("FAIL vg_instr got %h exp %h", o_instr, in0); end
    checks++; if (o_cycles !== cy0) begin errors++; $display("FAIL vg_cycles got %0d exp %0d", o_cycles, cy0); end
    checks++; if (pc0 !== 11'h081) begin errors++; $display("FAIL vg_pc_abs got %h exp 081", pc0); end
  endtask

  task automatic test_wrap();
    i_branch_taken = 1'b1; i_branch_addr = 11'h7FF;
    step();
    i_branch_taken = 1'b0;
    step();
    checks++; if (o_instr !== word(32'h7FF)) begin errors++; $display("FAIL wrap_instr got %h exp %h", o_instr, word(32'h7FF)); end
    checks++; if (o_imem_addr !== 11'd0) begin errors++; $display("FAIL wrap_pc got %h exp 0", o_imem_addr); end
    checks++; if (o_pc_next !== 11'd0) begin errors++; $display("FAIL wrap_pcn got %h exp 0", o_pc_next); end
  endtask

  task automatic test_halt();
    imem[3] = HALT_W;
    do_reset();
    i_valid = 1'b1;
    step(); step(); step();
    step();
    checks++; if (o_instr !== HALT_W) begin errors++; $display("FAIL halt_instr got %h exp %h", o_instr, HALT_W); end
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", o_halt); end
    checks++; if (o_imem_addr !== 11'd3) begin errors++; $display("FAIL halt_pc got %h exp 3", o_imem_addr); end
    checks++; if (o_pc_next !== 11'd4) begin errors++; $display("FAIL halt_pcn got %h exp 4", o_pc_next); end
    checks++; if (o_cycles !== 32'd4) begin errors++; $display("FAIL halt_cycles got %0d exp 4", o_cycles); end
    step();
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL halt_drain got %h exp 0", o_instr); end
    checks++; if (o_cycles !== 32'd4) begin errors++; $display("FAIL halt_frozen got %0d exp 4", o_cycles); end
    i_branch_taken = 1'b1; i_branch_addr = 11'h050;
    step(); step();
    i_branch_taken = 1'b0;
    checks++; if (o_imem_addr !== 11'd3) begin errors++; $display("FAIL halt_br_ignored got %h exp 3", o_imem_addr); end
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_stays got %b exp 1", o_halt); end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checks++; if (o_imem_addr !== 11'd0) begin errors++; $display("FAIL halt_rst_pc got %h exp 0", o_imem_addr); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL halt_rst_flag got %b exp 0", o_halt); end
    checks++; if (o_cycles !== 32'd0) begin errors++; $display("FAIL halt_rst_cycles got %0d exp 0", o_cycles); end
  endtask

  task automatic test_branch_over_halt();
    // imem[3] is still HALT; a branch at that fetch discards it.
    do_reset();
    i_valid = 1'b1;
    step(); step(); step();
    i_branch_taken = 1'b1; i_branch_addr = 11'h010;
    step();
    i_branch_taken = 1'b0;
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL boh_halt got %b exp 0", o_halt); end
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL boh_instr got %h exp 0", o_instr); end
    checks++; if (o_imem_addr !== 11'h010) begin errors++; $display("FAIL boh_pc got %h exp 010", o_imem_addr); end
    step();
    checks++; if (o_instr !== word(32'h10)) begin errors++; $display("FAIL boh_next got %h exp %h", o_instr, word(32'h10)); end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) imem[a] = word(a);
    test_reset();
    test_sequential();
    test_hazard();
    test_branch();
    test_hazard_over_branch();
    test_valid_gate();
    test_wrap();
    test_halt();
    test_branch_over_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
